// File: rtl/flexbus_initiator.sv
// FlexBus initiator: turns a single-outstanding valid/ready request into one
// multiplexed address/data FlexBus cycle (ADDR -> DATA -> TURN), or into a
// one-cycle error response when the address falls outside the bus window.
//
// Ports
//   FB_CLK, RST_n          clock, synchronous active-low reset
//   req_valid/req_ready    request handshake (ready only while idle)
//   req_rw/addr/wdata      request payload, latched on accept (rw: 1 = read)
//   rsp_valid/err/rdata    one-cycle completion pulse, error flag, read data
//   FB_ALE/CS/RW/OE        bus controls (ALE high, CS/OE low active)
//   FB_AD                  multiplexed address/data, tri-stated when not owned
module flexbus_initiator #(
    parameter logic [31:0] FB_BASE     = 32'h6000_0000,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        FB_CLK,
    input  logic        RST_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        FB_ALE,
    output logic        FB_CS,
    output logic        FB_RW,
    output logic        FB_OE,
    inout  wire  [31:0] FB_AD
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_TURN,
        S_ERR
    } state_t;

    localparam logic [3:0] W_LOAD = 4'(WAIT_STATES);

    state_t      r_state;
    state_t      w_nstate;
    logic [3:0]  r_cnt;
    logic        r_rw;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        r_ale;
    logic        r_cs;
    logic        r_rw_o;
    logic        r_oe;
    logic        r_ad_oe;
    logic [31:0] r_ad_out;
    logic        r_ready;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_in_win;
    logic        w_data_last;
    logic        w_rw_n;
    logic [31:0] w_addr_n;
    logic [31:0] w_wdata_n;
    logic        w_ale_n;
    logic        w_cs_n;
    logic        w_rw_o_n;
    logic        w_oe_n;
    logic        w_ad_oe_n;
    logic [31:0] w_ad_out_n;

    // Next-state logic
    always_comb begin
        w_nstate    = r_state;
        w_accept    = req_valid && (r_state == S_IDLE);
        w_in_win    = (req_addr[31:28] == FB_BASE[31:28]);
        w_data_last = (r_cnt == 4'd0);
        case (r_state)
            S_IDLE:  if (w_accept) w_nstate = w_in_win ? S_ADDR : S_ERR;
            S_ADDR:  w_nstate = S_DATA;
            S_DATA:  if (w_data_last) w_nstate = S_TURN;
            S_TURN:  w_nstate = S_IDLE;
            S_ERR:   w_nstate = S_IDLE;
            default: w_nstate = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from the *next* state and the *next* latched
    // payload, then registered, so every FB_* pin comes straight from a flop.
    always_comb begin
        w_rw_n     = w_accept ? req_rw    : r_rw;
        w_addr_n   = w_accept ? req_addr  : r_addr;
        w_wdata_n  = w_accept ? req_wdata : r_wdata;
        w_ale_n    = (w_nstate == S_ADDR);
        w_cs_n     = (w_nstate != S_DATA);
        w_rw_o_n   = 1'b1;
        w_oe_n     = 1'b1;
        w_ad_oe_n  = 1'b0;
        w_ad_out_n = w_wdata_n;
        if (w_nstate == S_ADDR) begin
            w_rw_o_n   = w_rw_n;
            w_ad_oe_n  = 1'b1;
            w_ad_out_n = w_addr_n;
        end else if (w_nstate == S_DATA) begin
            w_rw_o_n   = w_rw_n;
            w_oe_n     = !w_rw_n;
            // Never drive AD while the slave may be driving it (OE low)
            w_ad_oe_n  = !w_rw_n;
        end
    end

    always_ff @(posedge FB_CLK) begin
        if (!RST_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_rw        <= 1'b1;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_ale       <= 1'b0;
            r_cs        <= 1'b1;
            r_rw_o      <= 1'b1;
            r_oe        <= 1'b1;
            r_ad_oe     <= 1'b0;
            r_ad_out    <= 32'd0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rdata     <= 32'd0;
        end else begin
            r_state <= w_nstate;
            if (w_accept) begin
                r_rw    <= req_rw;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            // Loaded while in ADDR so DATA starts at WAIT_STATES and its
            // last cycle is the one where the counter reads zero.
            if (r_state == S_ADDR) begin
                r_cnt <= W_LOAD;
            end else if (r_state == S_DATA && !w_data_last) begin
                r_cnt <= r_cnt - 4'd1;
            end
            r_ale       <= w_ale_n;
            r_cs        <= w_cs_n;
            r_rw_o      <= w_rw_o_n;
            r_oe        <= w_oe_n;
            r_ad_oe     <= w_ad_oe_n;
            r_ad_out    <= w_ad_out_n;
            r_ready     <= (w_nstate == S_IDLE);
            r_rsp_valid <= (w_nstate == S_TURN) || (w_nstate == S_ERR);
            r_rsp_err   <= (w_nstate == S_ERR);
            if (w_nstate == S_ERR) begin
                r_rdata <= 32'd0;
            end else if (r_state == S_DATA && w_data_last && r_rw) begin
                r_rdata <= FB_AD;
            end
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rdata;
    assign FB_ALE    = r_ale;
    assign FB_CS     = r_cs;
    assign FB_RW     = r_rw_o;
    assign FB_OE     = r_oe;
    assign FB_AD     = r_ad_oe ? r_ad_out : 'z;

endmodule
